multi_regime_calc: RTL and testbench
====================================

Name: multi_regime_calc

Overview:
Parametrised successor to the single-width calculator core. It latches an operand `x` and a regime code on `start`, then iteratively computes one of three functions: square, cube, or integer square root. Every datapath width scales with `W`. It exposes state, busy, regime and accumulator observability outputs for debug, and sits as a leaf compute unit under the task top level.

Parameters:
W, 8, operand/result width in bits; must be even and >= 4
CNT_W, 8, iteration counter width; must satisfy 2^CNT_W > 2*W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
x  input  W  operand, sampled only when a start is accepted
on  input  2  regime request: 0 off, 1 square, 2 isqrt, 3 cube
start  input  1  start request, level-sampled in IDLE
y  output  W  last completed result, held until next DONE
s  output  3  current FSM state code
b  output  1  busy; high in LOAD, MUL1, MUL2, SQRT
active  output  1  combinational (on != 0)
regime  output  2  regime latched at start accept
real_state  output  W  live accumulator/partial-result register
done  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (rst low, asynchronous):
  - s = IDLE; y, real_state, regime = 0; b = 0; done = 0.
  - Internal operand, multiplier and counter registers = 0.
  - Reset during any state aborts the operation; no done pulse is produced.
- State codes: IDLE=0, LOAD=1, MUL1=2, MUL2=3, SQRT=4, DONE=5. Codes 6 and 7 are illegal and return to IDLE on the next clock.
- IDLE:
  - If start=1 and on!=0: latch x into opnd, latch on into regime, go to LOAD.
  - If start=1 and on=0: no action, stay in IDLE.
  - start is level-sensitive. If start is still high when the block re-enters IDLE, a new operation begins.
- LOAD (1 cycle):
  - Clear real_state and the counter.
  - Regime 1 or 3: mcand = opnd, mplier = opnd, go to MUL1.
  - Regime 2: set up the restoring-sqrt registers, go to SQRT.
- MUL1 (exactly W cycles): shift-add multiply. Each cycle, if mplier[0] is set, real_state += mcand (mod 2^W); then mcand <<= 1 and mplier >>= 1.
  - Regime 1: go to DONE after the W-th cycle.
  - Regime 3: set mcand = real_state, mplier = opnd, clear real_state, go to MUL2.
- MUL2 (W cycles): same shift-add operation, then go to DONE.
- SQRT (W/2 cycles): bit-pair restoring integer square root. real_state holds the partial root, zero-extended to W. Go to DONE after the last iteration.
- DONE (1 cycle):
  - y <= real_state, registered, so y changes on the edge that leaves DONE.
  - done = 1 during DONE; next state is IDLE.
- Arithmetic: all products are truncated modulo 2^W. The sqrt result is floor(sqrt(x)), which is always < 2^(W/2).
- Latency (start sampled at edge E0): DONE is entered at
  - E(W+1) for square,
  - E(2W+1) for cube,
  - E(W/2+1) for sqrt.
  y is updated at the following edge.
- Changes to on or x while b=1 are ignored, because values are latched. active tracks on live.
- A start while b=1 or in DONE is ignored and is not queued.

Test Plan:
1. W=8, rst low 4 ns, then x=5, on=1, start=1 at E0 -> b=1 E0..E9, done high after E9, y=25 after E10, regime=1, s returns to 0.
2. W=8, x=5, on=3, start pulse -> DONE entered at E17, y=125; x=255, on=3 -> y=255.
3. W=8, x=200, on=2 -> y=14 after E6; x=255 -> y=15; x=0 -> y=0; x=1 -> y=1.
4. W=8, x=200, on=1 -> y=64 (40000 mod 256); on=0 with start=1 -> s stays 0, b=0, active=0, y unchanged.
5. Start square x=5; at E3 set x=9, on=2, start=1 -> result still y=25, regime stays 1, no second operation until IDLE.
6. Assert rst low mid-MUL2 -> s, y, real_state, b, regime all 0 immediately; no done pulse. Repeat with W=16: x=300, on=1 -> y=24464 (90000 mod 65536).

Source files
------------

// File: rtl/multi_regime_calc.sv
// multi_regime_calc: iterative square / cube / integer-square-root unit.
// An operand and regime code are latched on start; the result appears on y
// one edge after the single-cycle DONE state.
module multi_regime_calc #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic [1:0]   on,
  input  logic         start,
  output logic [W-1:0] y,
  output logic [2:0]   s,
  output logic         b,
  output logic         active,
  output logic [1:0]   regime,
  output logic [W-1:0] real_state,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    SQRT = 3'd4,
    DONE = 3'd5
  } state_e;

  localparam logic [1:0]       REG_SQRT  = 2'd2;
  localparam logic [1:0]       REG_CUBE  = 2'd3;
  localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] SQRT_LAST = CNT_W'(W / 2 - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     mcand_q, mcand_d;    // multiplicand, or sqrt remainder
  logic [W-1:0]     mplier_q, mplier_d;  // multiplier, or sqrt radicand shifter
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;        // product accumulator / partial root
  logic [W-1:0]     y_q, y_d;
  logic [1:0]       regime_q, regime_d;

  // Shared datapath terms for the shift-add and restoring-sqrt steps.
  logic [W-1:0]     sum;
  logic [W+1:0]     rem_sh;
  logic [W+1:0]     trial;

  // Next-state and datapath update for every FSM state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    opnd_d   = opnd_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    y_d      = y_q;
    regime_d = regime_q;

    sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_sh = {mcand_q, mplier_q[W-1 -: 2]};
    trial  = {acc_q, 2'b01};

    unique case (state_q)
      IDLE: begin
        if (start && (on != 2'd0)) begin
          opnd_d   = x;
          regime_d = on;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        acc_d = '0;
        cnt_d = '0;
        if (regime_q == REG_SQRT) begin
          mcand_d  = '0;
          mplier_d = opnd_q;
          state_d  = SQRT;
        end else begin
          mcand_d  = opnd_q;
          mplier_d = opnd_q;
          state_d  = MUL1;
        end
      end
      MUL1, MUL2: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) begin
          cnt_d = '0;
          if ((state_q == MUL1) && (regime_q == REG_CUBE)) begin
            // Second pass multiplies the square by the operand again.
            mcand_d  = sum;
            mplier_d = opnd_q;
            acc_d    = '0;
            state_d  = MUL2;
          end else begin
            state_d = DONE;
          end
        end
      end
      SQRT: begin
        // Bring down the next bit pair; keep the trial subtraction if it fits.
        mplier_d = mplier_q << 2;
        cnt_d    = cnt_q + CNT_W'(1);
        if (rem_sh >= trial) begin
          mcand_d = W'(rem_sh - trial);
          acc_d   = {acc_q[W-2:0], 1'b1};
        end else begin
          mcand_d = W'(rem_sh);
          acc_d   = {acc_q[W-2:0], 1'b0};
        end
        if (cnt_q == SQRT_LAST) state_d = DONE;
      end
      DONE: begin
        y_d     = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register here, datapath included, is reset so an aborted operation leaves no stale operand behind.
    if (!rst) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      regime_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      regime_q <= regime_d;
    end
  end

  assign s          = state_q;
  assign b          = (state_q == LOAD) || (state_q == MUL1) ||
                      (state_q == MUL2) || (state_q == SQRT);
  assign done       = (state_q == DONE);
  assign active     = (on != 2'd0);
  assign regime     = regime_q;
  assign real_state = acc_q;
  assign y          = y_q;

endmodule

// File: tb/tb_multi_regime_calc.sv
// Scoreboard bench for multi_regime_calc at W=8 and W=16.
module tb_multi_regime_calc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  x8,  y8,  rs8;
  logic [15:0] x16, y16, rs16;
  logic [1:0]  on8, on16, reg8, reg16;
  logic        start8, start16, b8, b16, act8, act16, done8, done16;
  logic [2:0]  s8, s16;

  multi_regime_calc #(.W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .x(x8), .on(on8), .start(start8), .y(y8), .s(s8),
    .b(b8), .active(act8), .regime(reg8), .real_state(rs8), .done(done8)
  );

  multi_regime_calc #(.W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .x(x16), .on(on16), .start(start16), .y(y16), .s(s16),
    .b(b16), .active(act16), .regime(reg16), .real_state(rs16), .done(done16)
  );

  typedef struct {
    logic [1:0]  on;
    logic [15:0] y;
  } exp_t;

  exp_t q8[$], q16[$];
  exp_t cur8, cur16;
  bit   pend8 = 0, pend16 = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: the mathematical definition, truncated to w bits.
  function automatic logic [15:0] ref_calc(input int w, input logic [1:0] op, input logic [15:0] xv);
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned v = xv;
    longint unsigned r = 0;
    case (op)
      2'd1: return 16'((v * v) & m);
      2'd3: return 16'((v * v * v) & m);
      2'd2: begin
        while ((r + 1) * (r + 1) <= v) r++;
        return 16'(r);
      end
      default: return 16'd0;
    endcase
  endfunction

  function automatic int exp_latency(input int w, input logic [1:0] op);
    if (op == 2'd1) return w + 2;
    if (op == 2'd3) return 2 * w + 2;
    return w / 2 + 2;
  endfunction

  // Monitors: on a done pulse pop the expectation, check regime, then y one edge later.
  always @(negedge clk) begin
    if (!rst) pend8 = 0;
    else begin
      if (pend8) begin
        check("y8", y8, cur8.y);
        pend8 = 0;
      end
      if (done8) begin
        if (q8.size() == 0) fail("unexpected_done8");
        else begin
          cur8 = q8.pop_front();
          check("regime8", reg8, cur8.on);
          pend8 = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) pend16 = 0;
    else begin
      if (pend16) begin
        check("y16", y16, cur16.y);
        pend16 = 0;
      end
      if (done16) begin
        if (q16.size() == 0) fail("unexpected_done16");
        else begin
          cur16 = q16.pop_front();
          check("regime16", reg16, cur16.on);
          pend16 = 1;
        end
      end
    end
  end

  // One complete operation on the selected instance; call at a negedge.
  task automatic run_op(input int sel, input logic [15:0] xv, input logic [1:0] ov);
    int          w = (sel != 0) ? 16 : 8;
    int          k;
    logic [15:0] yprev;
    exp_t        e;
    k = 0;
    while ((((sel != 0) ? s16 : s8) != 3'd0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) fail("idle_timeout");
    yprev = (sel != 0) ? y16 : {8'h00, y8};
    if (sel != 0) begin x16 = xv; on16 = ov; start16 = 1'b1; end
    else begin x8 = xv[7:0]; on8 = ov; start8 = 1'b1; end
    if (ov != 2'd0) begin
      e.on = ov;
      e.y  = ref_calc(w, ov, (sel != 0) ? xv : {8'h00, xv[7:0]});
      if (sel != 0) q16.push_back(e); else q8.push_back(e);
    end
    @(negedge clk);
    if (sel != 0) start16 = 1'b0; else start8 = 1'b0;
    if (ov == 2'd0) begin
      check("off_state", (sel != 0) ? s16 : s8, 0);
      check("off_busy", (sel != 0) ? b16 : b8, 0);
      check("off_active", (sel != 0) ? act16 : act8, 0);
      check("off_y_held", (sel != 0) ? y16 : {8'h00, y8}, yprev);
      return;
    end
    check("busy_after_start", (sel != 0) ? b16 : b8, 1);
    k = 1;
    while (!((sel != 0) ? done16 : done8) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) fail("done_timeout");
    else check("latency", k, exp_latency(w, ov));
    @(negedge clk);
    check("done_one_cycle", (sel != 0) ? done16 : done8, 0);
    check("back_to_idle", (sel != 0) ? s16 : s8, 0);
  endtask

  exp_t e5;
  int   k5;

  initial begin
    rst = 1'b0;
    x8 = '0; on8 = '0; start8 = 1'b0;
    x16 = '0; on16 = '0; start16 = 1'b0;
    #2;
    check("rst_s8", s8, 0);         check("rst_y8", y8, 0);
    check("rst_b8", b8, 0);         check("rst_done8", done8, 0);
    check("rst_regime8", reg8, 0);  check("rst_rs8", rs8, 0);
    check("rst_s16", s16, 0);       check("rst_y16", y16, 0);
    check("rst_active8", act8, 0);
    #2 rst = 1'b1;
    @(negedge clk);

    // Directed W=8 cases, including extremes of the operand range.
    run_op(0, 5, 1);    run_op(0, 5, 3);    run_op(0, 255, 3);
    run_op(0, 200, 2);  run_op(0, 255, 2);  run_op(0, 0, 2);
    run_op(0, 1, 2);    run_op(0, 200, 1);  run_op(0, 77, 0);
    run_op(0, 0, 1);    run_op(0, 255, 1);  run_op(0, 3, 0);

    // Start while busy is ignored; a start still held at IDLE launches a new op.
    x8 = 5; on8 = 1; start8 = 1'b1;
    e5.on = 2'd1; e5.y = 16'd25; q8.push_back(e5);
    e5.on = 2'd2; e5.y = 16'd3;  q8.push_back(e5);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); @(negedge clk);
    x8 = 9; on8 = 2; start8 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("busy_regime_held", reg8, 1);
      check("busy_still", b8, 1);
      check("active_live", act8, 1);
    end
    k5 = 0;
    while (!done8 && k5 < 100) begin @(negedge clk); k5++; end
    if (k5 >= 100) fail("t5_done_timeout");
    k5 = 0;
    while (s8 != 3'd1 && k5 < 10) begin @(negedge clk); k5++; end
    if (k5 >= 10) fail("t5_restart_timeout");
    start8 = 1'b0;
    k5 = 0;
    while (!done8 && k5 < 100) begin @(negedge clk); k5++; end
    if (k5 >= 100) fail("t5_second_done_timeout");
    @(negedge clk);

    // Reset mid-MUL2 aborts with no done pulse.
    run_op(0, 7, 1);
    x8 = 5; on8 = 3; start8 = 1'b1;
    e5.on = 2'd3; e5.y = 16'd125; q8.push_back(e5);
    @(negedge clk); start8 = 1'b0;
    k5 = 0;
    while (s8 != 3'd3 && k5 < 50) begin @(negedge clk); k5++; end
    if (k5 >= 50) fail("mul2_timeout");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_s", s8, 0);        check("abort_y", y8, 0);
    check("abort_rs", rs8, 0);      check("abort_b", b8, 0);
    check("abort_regime", reg8, 0);
    q8.delete();
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", done8, 0);
    end
    rst = 1'b1;
    run_op(0, 6, 3);

    // Random W=8 traffic.
    for (int i = 0; i < 30; i++)
      run_op(0, 16'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));

    // W=16 instance: directed extremes then random.
    run_op(1, 300, 1);    run_op(1, 65535, 2);  run_op(1, 0, 3);
    run_op(1, 65535, 3);  run_op(1, 12345, 2);  run_op(1, 1, 2);
    for (int i = 0; i < 12; i++)
      run_op(1, 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)));

    repeat (3) @(negedge clk);
    if (q8.size() != 0) fail("leftover_expect8");
    if (q16.size() != 0) fail("leftover_expect16");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
